// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 Set 2 scan-code decoder feeding two held-key slots
// Optional KEY_EXTENDED_FLAG_EN keeps the E0 flag per slot and matches keys on {ext, code}.

module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 1100000,
  parameter int CNT_W          = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  output logic       key1_on,
  output logic [7:0] key1_code,
  output logic       key2_on,
  output logic [7:0] key2_code,
  output logic       prefix_err
`ifdef KEY_EXTENDED_FLAG_EN
  ,
  output logic       key1_ext,
  output logic       key2_ext
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef KEY_EXTENDED_FLAG_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             k1_on_q, k1_on_d;
  logic [7:0]       k1_code_q, k1_code_d;
  logic             k1_ext_q, k1_ext_d;
  logic             k2_on_q, k2_on_d;
  logic [7:0]       k2_code_q, k2_code_d;
  logic             k2_ext_q, k2_ext_d;

  logic       is_e0, is_f0, is_ignored;
  logic       make_evt, brk_evt, evt_ext_raw, evt_ext;
  logic       hit1, hit2;

  assign is_e0 = (ps2_data == 8'hE0);
  assign is_f0 = (ps2_data == 8'hF0);
  assign is_ignored = (ps2_data == 8'h00) || (ps2_data == 8'hAA) || (ps2_data == 8'hEE) ||
                      (ps2_data == 8'hFA) || (ps2_data == 8'hFE) || (ps2_data == 8'hFF) ||
                      (ps2_data == 8'hE1);

  // Prefix decoding; a fresh E0/F0 inside a prefix restarts decoding from that byte.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    make_evt    = 1'b0;
    brk_evt     = 1'b0;
    evt_ext_raw = 1'b0;
    if (ps2_valid) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (is_e0)           state_d = S_EXT;
          else if (is_f0)      state_d = S_BRK;
          else if (!is_ignored) make_evt = 1'b1;
        end
        S_EXT: begin
          if (is_e0)      state_d = S_EXT;
          else if (is_f0) state_d = S_EXT_BRK;
          else begin
            make_evt    = 1'b1;
            evt_ext_raw = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          if (is_e0)      state_d = S_EXT;
          else if (is_f0) state_d = S_BRK;
          else begin
            brk_evt     = 1'b1;
            evt_ext_raw = (state_q == S_EXT_BRK);
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == TIMEOUT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Without the ext feature every event and slot carries ext=0, so matching reduces to the code.
  assign evt_ext = EXT_EN & evt_ext_raw;
  assign hit1 = k1_on_q && ({k1_ext_q, k1_code_q} == {evt_ext, ps2_data});
  assign hit2 = k2_on_q && ({k2_ext_q, k2_code_q} == {evt_ext, ps2_data});

  always_comb begin
    k1_on_d   = k1_on_q;
    k1_code_d = k1_code_q;
    k1_ext_d  = k1_ext_q;
    k2_on_d   = k2_on_q;
    k2_code_d = k2_code_q;
    k2_ext_d  = k2_ext_q;
    if (make_evt && !hit1 && !hit2) begin
      if (!k1_on_q) begin
        k1_on_d   = 1'b1;
        k1_code_d = ps2_data;
        k1_ext_d  = evt_ext;
      end else if (!k2_on_q) begin
        k2_on_d   = 1'b1;
        k2_code_d = ps2_data;
        k2_ext_d  = evt_ext;
      end
    end
    if (brk_evt) begin
      if (hit1) k1_on_d = 1'b0;
      if (hit2) k2_on_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      k1_on_q   <= 1'b0;
      k1_code_q <= 8'h00;
      k1_ext_q  <= 1'b0;
      k2_on_q   <= 1'b0;
      k2_code_q <= 8'h00;
      k2_ext_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      k1_on_q   <= k1_on_d;
      k1_code_q <= k1_code_d;
      k1_ext_q  <= k1_ext_d;
      k2_on_q   <= k2_on_d;
      k2_code_q <= k2_code_d;
      k2_ext_q  <= k2_ext_d;
    end
  end

  assign key1_on    = k1_on_q;
  assign key1_code  = k1_code_q;
  assign key2_on    = k2_on_q;
  assign key2_code  = k2_code_q;
  assign prefix_err = err_q;
`ifdef KEY_EXTENDED_FLAG_EN
  assign key1_ext = k1_ext_q;
  assign key2_ext = k2_ext_q;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed and randomized check of ps2_key_tracker against a slot model
// Honours KEY_EXTENDED_FLAG_EN when the design is built with it.

module tb_ps2_key_tracker;

  localparam int T = 100;
`ifdef KEY_EXTENDED_FLAG_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       key1_on, key2_on, prefix_err;
  logic [7:0] key1_code, key2_code;
  logic       dut_e1, dut_e2;

  int vectors = 0;
  int miscompares = 0;

  bit         m_on[2];
  logic [8:0] m_key[2];
  bit         pend_e0, pend_f0, m_err;
  int         idle_cnt;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .key1_on(key1_on), .key1_code(key1_code), .key2_on(key2_on), .key2_code(key2_code),
    .prefix_err(prefix_err)
`ifdef KEY_EXTENDED_FLAG_EN
    , .key1_ext(dut_e1), .key2_ext(dut_e2)
`endif
  );
`ifndef KEY_EXTENDED_FLAG_EN
  assign dut_e1 = 1'b0;
  assign dut_e2 = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input bit e, input logic [7:0] c);
    return {EXT_EN & e, c};
  endfunction

  task automatic m_make(input logic [8:0] k);
    if ((m_on[0] && m_key[0] == k) || (m_on[1] && m_key[1] == k)) return;
    for (int i = 0; i < 2; i++)
      if (!m_on[i]) begin
        m_on[i]  = 1'b1;
        m_key[i] = k;
        return;
      end
  endtask

  task automatic m_break(input logic [8:0] k);
    for (int i = 0; i < 2; i++)
      if (m_on[i] && m_key[i] == k) m_on[i] = 1'b0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_on[i]  = 1'b0;
      m_key[i] = 9'h0;
    end
    pend_e0 = 1'b0; pend_f0 = 1'b0; m_err = 1'b0; idle_cnt = 0;
  endtask

  task automatic m_step(input bit v, input logic [7:0] d);
    bit ign;
    m_err = 1'b0;
    ign = (d == 8'h00) || (d == 8'hAA) || (d == 8'hEE) || (d == 8'hFA) ||
          (d == 8'hFE) || (d == 8'hFF) || (d == 8'hE1);
    if (v) begin
      idle_cnt = 0;
      if (d == 8'hE0) begin
        pend_e0 = 1'b1; pend_f0 = 1'b0;
      end else if (d == 8'hF0) begin
        if (pend_f0) pend_e0 = 1'b0;
        pend_f0 = 1'b1;
      end else begin
        if (pend_f0)      m_break(mk(pend_e0, d));
        else if (pend_e0) m_make(mk(1'b1, d));
        else if (!ign)    m_make(mk(1'b0, d));
        pend_e0 = 1'b0; pend_f0 = 1'b0;
      end
    end else if (pend_e0 || pend_f0) begin
      idle_cnt++;
      if (idle_cnt == T) begin
        pend_e0 = 1'b0; pend_f0 = 1'b0; m_err = 1'b1; idle_cnt = 0;
      end
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {11'b0, prefix_err, key1_on, key1_code, key2_on, key2_code, dut_e1, dut_e2};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {11'b0, m_err, m_on[0], m_key[0][7:0], m_on[1], m_key[1][7:0], m_key[0][8], m_key[1][8]};
  endfunction

  task automatic tick(input bit v, input logic [7:0] d);
    ps2_valid = v;
    ps2_data  = d;
    @(posedge clock);
    m_step(v, d);
    #1;
    chk("model", dut_vec(), exp_vec());
    ps2_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ps2_valid = 1'b0;
    @(posedge clock);
    m_reset();
    #1;
    chk("reset_outputs", dut_vec(), 32'h0);
    reset = 1'b0;
  endtask

  logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h72, 8'hAA, 8'h00, 8'hF0};
  int rises, err_cnt, err_at, r;
  logic prev_on;

  initial begin
    m_reset();
    @(posedge clock);
    do_reset();

    // single key press and release
    send(8'h1C);
    chk("press_k1_on", key1_on, 1);
    chk("press_k1_code", key1_code, 8'h1C);
    send(8'hF0); send(8'h1C);
    chk("release_k1_on", key1_on, 0);
    chk("release_k1_code", key1_code, 8'h1C);
    chk("release_k2_on", key2_on, 0);

    // two keys, third dropped, then refill of slot 1
    send(8'h1C); send(8'h1B); send(8'h23);
    chk("two_k1", {key1_on, key1_code}, {1'b1, 8'h1C});
    chk("two_k2", {key2_on, key2_code}, {1'b1, 8'h1B});
    send(8'hF0); send(8'h1C); send(8'h23);
    chk("refill_k1", {key1_on, key1_code}, {1'b1, 8'h23});
    chk("refill_k2", {key2_on, key2_code}, {1'b1, 8'h1B});
    send(8'hF0); send(8'h23); send(8'hF0); send(8'h1B);
    chk("all_released", {key1_on, key2_on}, 2'b00);

    // typematic repeat
    rises = 0; prev_on = key1_on;
    for (int i = 0; i < 5; i++) begin
      send(8'h1C);
      if (key1_on && !prev_on) rises++;
      prev_on = key1_on;
    end
    chk("repeat_rises", rises, 1);
    chk("repeat_k2_on", key2_on, 0);
    send(8'hF0); send(8'h1C);

    // extended key
    send(8'hE0); send(8'h75);
    chk("ext_make", {key1_on, key1_code}, {1'b1, 8'h75});
    chk("ext_flag", dut_e1, EXT_EN);
    if (EXT_EN) begin
      send(8'hF0); send(8'h75);
      chk("plain_break_keeps_ext", key1_on, 1);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_break", key1_on, 0);

    // prefix timeout
    send(8'hF0);
    err_cnt = 0; err_at = -1;
    for (int i = 1; i <= T + 5; i++) begin
      tick(1'b0, 8'h00);
      if (prefix_err) begin
        err_cnt++;
        err_at = i;
      end
    end
    chk("timeout_pulses", err_cnt, 1);
    chk("timeout_cycle", err_at, T);
    send(8'h1C);
    chk("after_timeout_make", {key1_on, key1_code}, {1'b1, 8'h1C});

    // byte arriving on the expiry cycle wins over the timeout
    send(8'hF0);
    idle(T - 1);
    send(8'h1C);
    chk("expiry_byte_break", key1_on, 0);
    chk("expiry_no_err", prefix_err, 0);

    // reset mid-sequence
    send(8'h1C); send(8'hE0);
    do_reset();
    send(8'h72);
    chk("post_reset_make", {key1_on, key1_code, dut_e1}, {1'b1, 8'h72, 1'b0});
    chk("post_reset_k2", key2_on, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 4)       idle($urandom_range(T - 3, T + 3));
      else if (r == 4) do_reset();
      else if (r < 90) tick(1'b0, 8'h00);
      else             send(pool[$urandom_range(0, 9)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
